// File: rtl/i2c_share_arbiter_pkg.sv
// Shared types and constants for the I2C share arbiter.
package i2c_share_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDrain,
    StAbort
  } arb_state_e;

  // Command word layout; the arbiter itself treats words as opaque.
  localparam int unsigned CmdW          = 10;
  localparam int unsigned CmdStartBit   = 9;
  localparam int unsigned CmdStopBit    = 8;
  localparam int unsigned CmdByteMsb    = 7;

  // 10 ms at 50 MHz.
  localparam int unsigned DefTimeoutCyc = 500000;

endpackage

// File: rtl/i2c_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, with wrap.
module i2c_share_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [IDX_W-1:0] w_sel;

  always_comb begin
    o_pick  = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      w_sel = IDX_W'((32'(i_last) + k) % N_REQ);
      if (!o_found && i_req[w_sel]) begin
        o_found       = 1'b1;
        o_idx         = w_sel;
        o_pick[w_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_share_arbiter.sv
// Shares one byte-level I2C master between N_REQ clients: round-robin ownership per
// transaction, command/response muxing, in-flight limit and a hung-owner watchdog.
module i2c_share_arbiter
  import i2c_share_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned CMD_W       = CmdW,
  parameter int unsigned MAX_OUT     = 4,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
  input  logic                   clk_50,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       gnt,
  input  logic [N_REQ-1:0]       cmd_valid,
  input  logic [N_REQ*CMD_W-1:0] cmd_data,
  output logic [N_REQ-1:0]       cmd_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_nack,
  output logic [N_REQ-1:0]       timeout_err,
  output logic                   m_cmd_valid,
  output logic [CMD_W-1:0]       m_cmd_data,
  input  logic                   m_cmd_ready,
  input  logic                   m_rsp_valid,
  input  logic [7:0]             m_rsp_data,
  input  logic                   m_rsp_nack,
  input  logic                   m_busy,
  output logic                   m_abort
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned OutW = 4;

  arb_state_e       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IdxW-1:0]  r_owner;
  logic [IdxW-1:0]  r_last;
  logic [OutW-1:0]  r_outst;
  logic [WdW-1:0]   r_wdog;
  logic [N_REQ-1:0] r_terr;
  logic             r_abort;

  logic [N_REQ-1:0] w_pick;
  logic [IdxW-1:0]  w_pick_idx;
  logic             w_found;
  logic             w_active;
  logic             w_can_issue;
  logic             w_cmd_hs;
  logic             w_rsp_live;
  logic             w_wdog_exp;
  logic [OutW-1:0]  w_outst_nxt;

  i2c_share_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IdxW)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_active    = (r_state == StGrant) || (r_state == StDrain);
  assign w_can_issue = (r_state == StGrant) && (r_outst < OutW'(MAX_OUT));
  assign m_cmd_valid = w_can_issue & cmd_valid[r_owner];
  assign m_cmd_data  = cmd_data[r_owner*CMD_W +: CMD_W];
  assign w_cmd_hs    = m_cmd_valid & m_cmd_ready;
  // A response with nothing in flight is stray and never reaches a client.
  assign w_rsp_live  = m_rsp_valid && w_active && (r_outst != '0);
  assign w_outst_nxt = r_outst + OutW'(w_cmd_hs) - OutW'(w_rsp_live);
  assign w_wdog_exp  = (r_wdog == WdW'(TIMEOUT_CYC - 1)) && !w_cmd_hs && !w_rsp_live;

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign cmd_ready[i] = r_gnt[i] & w_can_issue & m_cmd_ready;
    assign rsp_valid[i] = r_gnt[i] & w_rsp_live;
  end

  assign rsp_data    = m_rsp_data;
  assign rsp_nack    = m_rsp_nack;
  assign gnt         = r_gnt;
  assign timeout_err = r_terr;
  assign m_abort     = r_abort;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IdxW'(N_REQ - 1);
      r_outst <= '0;
      r_wdog  <= '0;
      r_terr  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_terr  <= '0;
      r_abort <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_gnt   <= w_pick;
            r_owner <= w_pick_idx;
            r_wdog  <= '0;
            r_state <= StGrant;
          end
        end
        StGrant, StDrain: begin
          if (w_wdog_exp) begin
            r_terr  <= r_gnt;
            r_abort <= 1'b1;
            r_gnt   <= '0;
            r_outst <= '0;
            r_state <= StAbort;
          end else begin
            r_outst <= w_outst_nxt;
            r_wdog  <= (w_cmd_hs || w_rsp_live) ? '0 : r_wdog + WdW'(1);
            if (r_state == StGrant && !req[r_owner]) begin
              r_state <= StDrain;
            end else if (r_state == StDrain && r_outst == '0 && !m_busy) begin
              r_gnt   <= '0;
              r_last  <= r_owner;
              r_state <= StIdle;
            end
          end
        end
        StAbort: begin
          if (!m_busy) begin
            r_last  <= r_owner;
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_share_arbiter.sv
// Scoreboard bench for i2c_share_arbiter with a short watchdog (TIMEOUT_CYC=16).
module tb_i2c_share_arbiter;

  localparam int unsigned NReq = 2;
  localparam int unsigned CmdW = 10;

  logic                  clk_50 = 1'b0;
  logic                  reset_n;
  logic [NReq-1:0]       req, gnt, cmd_valid, cmd_ready, rsp_valid, timeout_err;
  logic [NReq*CmdW-1:0]  cmd_data;
  logic [7:0]            rsp_data, m_rsp_data;
  logic                  rsp_nack, m_cmd_valid, m_cmd_ready, m_rsp_valid, m_rsp_nack;
  logic                  m_busy, m_abort;
  logic [CmdW-1:0]       m_cmd_data;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_hs  = 0;
  logic [31:0] cmd_q[$];
  logic [31:0] rsp_q[$];

  i2c_share_arbiter #(
    .N_REQ       (NReq),
    .CMD_W       (CmdW),
    .MAX_OUT     (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .req         (req),
    .gnt         (gnt),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_nack    (rsp_nack),
    .timeout_err (timeout_err),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_data  (m_cmd_data),
    .m_cmd_ready (m_cmd_ready),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_data  (m_rsp_data),
    .m_rsp_nack  (m_rsp_nack),
    .m_busy      (m_busy),
    .m_abort     (m_abort)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cmd_drive(input int r, input logic [CmdW-1:0] w);
    cmd_valid = '0;
    cmd_valid[r] = 1'b1;
    cmd_data[r*CmdW +: CmdW] = w;
    cmd_q.push_back(32'(w));
  endtask

  task automatic rsp_pulse(input logic [7:0] d, input logic nk, input logic [1:0] to);
    m_rsp_valid = 1'b1;
    m_rsp_data  = d;
    m_rsp_nack  = nk;
    if (to != 2'b00) rsp_q.push_back({21'b0, to, nk, d});
    tick(1);
    m_rsp_valid = 1'b0;
  endtask

  // Handshakes are judged mid-cycle, where inputs and combinational outputs are stable.
  always @(negedge clk_50) begin
    if (reset_n && m_cmd_valid && m_cmd_ready) begin
      n_hs++;
      check_eq("cmd_data", 32'(m_cmd_data), (cmd_q.size() != 0) ? cmd_q.pop_front() : 32'hDEAD);
    end
    if (reset_n && rsp_valid != '0) begin
      check_eq("rsp_route", {21'b0, rsp_valid, rsp_nack, rsp_data},
               (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'hDEAD);
    end
  end

  initial begin
    reset_n     = 1'b0;
    req         = '0;
    cmd_valid   = 2'b11;
    cmd_data    = '0;
    m_cmd_ready = 1'b1;
    m_rsp_valid = 1'b1;
    m_rsp_data  = 8'h00;
    m_rsp_nack  = 1'b0;
    m_busy      = 1'b0;
    #1;
    check_eq("rst_gnt", 32'(gnt), 0);
    check_eq("rst_terr", 32'(timeout_err), 0);
    check_eq("rst_abort", 32'(m_abort), 0);
    check_eq("rst_mvalid", 32'(m_cmd_valid), 0);
    check_eq("rst_cready", 32'(cmd_ready), 0);
    check_eq("rst_rvalid", 32'(rsp_valid), 0);
    m_rsp_valid = 1'b0;
    cmd_valid   = '0;
    tick(2);

    // 1: req0 has first priority, drop -> idle gap -> req1
    reset_n = 1'b1;
    req     = 2'b11;
    tick(1);
    check_eq("t1_first", 32'(gnt), 'h1);
    req = 2'b10;
    tick(1);
    check_eq("t1_drain", 32'(gnt), 'h1);
    tick(1);
    check_eq("t1_gap", 32'(gnt), 'h0);
    tick(1);
    check_eq("t1_next", 32'(gnt), 'h2);
    req = 2'b00;
    tick(2);
    check_eq("t1_release", 32'(gnt), 'h0);

    // 2: in-flight limit of 4 with a silent master
    req = 2'b01;
    tick(1);
    check_eq("t2_gnt", 32'(gnt), 'h1);
    for (int i = 0; i < 4; i++) begin
      cmd_drive(0, CmdW'(10'h210 + i));
      settle();
      check_eq("t2_rdy", 32'(cmd_ready), 'h1);
      tick(1);
    end
    cmd_drive(0, 10'h0FF);
    settle();
    check_eq("t2_full_rdy", 32'(cmd_ready), 'h0);
    check_eq("t2_full_mv", 32'(m_cmd_valid), 'h0);
    tick(2);
    check_eq("t2_stall", 32'(cmd_ready), 'h0);
    check_eq("t2_hs4", n_hs, 4);
    m_rsp_valid = 1'b1;
    m_rsp_data  = 8'h3C;
    rsp_q.push_back({21'b0, 2'b01, 1'b0, 8'h3C});
    settle();
    check_eq("t2_rsp_cyc", 32'(cmd_ready), 'h0);
    tick(1);
    m_rsp_valid = 1'b0;
    settle();
    check_eq("t2_resume", 32'(cmd_ready), 'h1);
    tick(1);
    cmd_valid = '0;
    check_eq("t2_hs5", n_hs, 5);

    // 3: simultaneous cmd + rsp, owner-only routing, pending req1
    req = 2'b11;
    rsp_pulse(8'h11, 1'b1, 2'b01);
    cmd_drive(0, 10'h155);
    m_rsp_valid = 1'b1;
    m_rsp_data  = 8'hA5;
    m_rsp_nack  = 1'b0;
    rsp_q.push_back({21'b0, 2'b01, 1'b0, 8'hA5});
    settle();
    check_eq("t3_same_rdy", 32'(cmd_ready), 'h1);
    check_eq("t3_pass", {rsp_valid, rsp_data}, 'h1A5);
    tick(1);
    m_rsp_valid = 1'b0;
    cmd_drive(0, 10'h2AA);
    settle();
    check_eq("t3_out_same", 32'(cmd_ready), 'h1);
    tick(1);
    cmd_valid = '0;
    settle();
    check_eq("t3_full", 32'(cmd_ready), 'h0);
    check_eq("t3_pending", 32'(gnt), 'h1);
    for (int i = 0; i < 4; i++) rsp_pulse(8'h40 + 8'(i), i[0], 2'b01);
    rsp_pulse(8'hEE, 1'b0, 2'b00);
    req = 2'b10;
    tick(3);
    check_eq("t3_handover", 32'(gnt), 'h2);

    // 4: owner 1 hangs -> abort after 16 idle cycles
    m_busy = 1'b1;
    cmd_drive(1, 10'h3C3);
    settle();
    check_eq("t4_rdy", 32'(cmd_ready), 'h2);
    tick(1);
    cmd_valid = '0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check_eq("t4_wait", {timeout_err, m_abort, gnt}, 'h02);
    end
    tick(1);
    check_eq("t4_abort", {timeout_err, m_abort, gnt}, 'h14);
    req         = 2'b00;
    m_rsp_valid = 1'b1;
    m_rsp_data  = 8'h77;
    settle();
    check_eq("t4_late_drop", 32'(rsp_valid), 'h0);
    tick(1);
    m_rsp_valid = 1'b0;
    check_eq("t4_one_pulse", {timeout_err, m_abort, gnt}, 'h00);
    req = 2'b01;
    tick(2);
    check_eq("t4_busy_wait", 32'(gnt), 'h0);
    m_busy = 1'b0;
    tick(1);
    check_eq("t4_idle", 32'(gnt), 'h0);
    tick(1);
    check_eq("t4_regrant", 32'(gnt), 'h1);

    // 5: drain holds gnt until responses are in and master is idle
    m_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_drive(0, CmdW'(10'h100 + i));
      settle();
      check_eq("t5_rdy", 32'(cmd_ready), 'h1);
      tick(1);
    end
    cmd_valid = '0;
    rsp_pulse(8'h81, 1'b0, 2'b01);
    rsp_pulse(8'h82, 1'b1, 2'b01);
    req = 2'b00;
    tick(1);
    check_eq("t5_drain", 32'(gnt), 'h1);
    cmd_valid = 2'b01;
    cmd_data[CmdW-1:0] = 10'h3FF;
    settle();
    check_eq("t5_block_rdy", 32'(cmd_ready), 'h0);
    check_eq("t5_block_mv", 32'(m_cmd_valid), 'h0);
    tick(2);
    cmd_valid = '0;
    check_eq("t5_hold", 32'(gnt), 'h1);
    rsp_pulse(8'h91, 1'b0, 2'b01);
    rsp_pulse(8'h92, 1'b0, 2'b01);
    tick(1);
    check_eq("t5_busy_hold", 32'(gnt), 'h1);
    m_busy = 1'b0;
    tick(1);
    check_eq("t5_release", 32'(gnt), 'h0);

    // 6: asynchronous reset mid-grant
    req = 2'b10;
    tick(1);
    check_eq("t6_gnt", 32'(gnt), 'h2);
    cmd_drive(1, 10'h2C1);
    tick(1);
    cmd_valid = 2'b10;
    cmd_data[CmdW +: CmdW] = 10'h0D0;
    m_rsp_valid = 1'b1;
    m_rsp_data  = 8'h5A;
    settle();
    check_eq("t6_pre_mv", 32'(m_cmd_valid), 'h1);
    check_eq("t6_pre_rv", 32'(rsp_valid), 'h2);
    reset_n = 1'b0;
    settle();
    check_eq("t6_rst_gnt", 32'(gnt), 'h0);
    check_eq("t6_rst_mv", 32'(m_cmd_valid), 'h0);
    check_eq("t6_rst_rv", 32'(rsp_valid), 'h0);
    check_eq("t6_rst_cr", 32'(cmd_ready), 'h0);
    cmd_valid   = '0;
    m_rsp_valid = 1'b0;
    req         = '0;
    tick(1);
    reset_n = 1'b1;
    req     = 2'b10;
    tick(1);
    check_eq("t6_after", 32'(gnt), 'h2);
    req = '0;
    tick(3);
    check_eq("cmd_q_left", cmd_q.size(), 0);
    check_eq("rsp_q_left", rsp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
